// File: rtl/aes_pkg.sv
// Shared constants and loader state encoding for the AES bit-serial front end.
package aes_pkg;

    localparam int AES_BLK_BITS  = 128;
    localparam int AES_BYTE_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        DELAY,
        SHIFT,
        DRAIN
    } loader_state_e;

endpackage

// File: rtl/aes_dual_piso.sv
// Two parallel-in/serial-out registers sharing load and shift enables; both MSBs
// are exposed so the operands leave in lockstep.
module aes_dual_piso import aes_pkg::*; #(
    parameter int W = AES_BLK_BITS
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         a_msb_o,
    output logic         b_msb_o
);

    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (load_i) begin
            a_d = a_i;
            b_d = b_i;
        end else if (shift_i) begin
            a_d = {a_q[W-2:0], 1'b0};
            b_d = {b_q[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign a_msb_o = a_q[W-1];
    assign b_msb_o = b_q[W-1];

endmodule

// File: rtl/aes_bit_loader.sv
// Feeds one plaintext/key pair to the AES control unit: start pulse, optional
// launch delay, lockstep bit-serial streaming, then wait for the unit to go idle.
//
// state  | meaning
// IDLE   | ready for a block whenever the control unit is not busy
// LAUNCH | one-cycle Data_Valid start pulse
// DELAY  | covers the control unit's start-state entry latency
// SHIFT  | one bit of each operand per cycle, byte 0 first, MSB first
// DRAIN  | serial lines parked low until busy_in falls
module aes_bit_loader import aes_pkg::*; #(
    parameter int LAUNCH_DELAY = 1,
    parameter int BLK_BITS     = AES_BLK_BITS,
    parameter int CNT_W        = 8
) (
    input  logic                clock,
    input  logic                Reset,
    input  logic [BLK_BITS-1:0] pt_block,
    input  logic [BLK_BITS-1:0] key_block,
    input  logic                blk_valid,
    output logic                blk_ready,
    input  logic                busy_in,
    output logic                Data_Valid,
    output logic                DataIN_mem,
    output logic                DataIN_cipher,
    output logic                proto_err,
    output logic [CNT_W-1:0]    blocks_sent
);

    if (BLK_BITS % AES_BYTE_BITS != 0) begin : g_bad_blk_bits
        $error("BLK_BITS must be a whole number of bytes");
    end

    localparam int            BW       = (BLK_BITS > 1) ? $clog2(BLK_BITS) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(BLK_BITS - 1);
    localparam int            DLY_LOAD = (LAUNCH_DELAY > 2) ? LAUNCH_DELAY - 2 : 0;
    localparam int            DW       = (DLY_LOAD > 0) ? $clog2(DLY_LOAD + 1) : 1;

    loader_state_e    state_q, state_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [DW-1:0]    dly_q, dly_d;
    logic [CNT_W-1:0] sent_q, sent_d;
    logic             err_q, err_d;
    logic             dv_q, mem_q, cip_q;
    logic             accept, shift_en, pt_msb, key_msb;

    assign blk_ready = (state_q == IDLE) && !busy_in;
    assign accept    = blk_valid && blk_ready;
    assign shift_en  = (state_d == SHIFT);

    aes_dual_piso #(.W(BLK_BITS)) u_piso (
        .clk_i   (clock),
        .rst_i   (Reset),
        .load_i  (accept),
        .shift_i (shift_en),
        .a_i     (pt_block),
        .b_i     (key_block),
        .a_msb_o (pt_msb),
        .b_msb_o (key_msb)
    );

    always_comb begin
        state_d = state_q;
        bit_d   = '0;
        dly_d   = dly_q;
        sent_d  = sent_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: if (accept) state_d = LAUNCH;
            LAUNCH: begin
                if (busy_in) err_d = 1'b1;
                if (LAUNCH_DELAY > 1) begin
                    state_d = DELAY;
                    dly_d   = DW'(DLY_LOAD);
                end else begin
                    state_d = SHIFT;
                end
            end
            DELAY: begin
                if (dly_q == '0) state_d = SHIFT;
                else             dly_d   = dly_q - 1'b1;
            end
            SHIFT: begin
                // The control unit raises Busy on the first bit, so only later bits are policed.
                if (bit_q != '0 && !busy_in) err_d = 1'b1;
                if (bit_q == LAST_BIT) begin
                    state_d = DRAIN;
                    sent_d  = sent_q + 1'b1;
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
            DRAIN: if (!busy_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (Reset) begin
            state_q <= IDLE;
            bit_q   <= '0;
            dly_q   <= '0;
            sent_q  <= '0;
            err_q   <= 1'b0;
            dv_q    <= 1'b0;
            mem_q   <= 1'b0;
            cip_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            dly_q   <= dly_d;
            sent_q  <= sent_d;
            err_q   <= err_d;
            dv_q    <= (state_d == LAUNCH);
            mem_q   <= shift_en & pt_msb;
            cip_q   <= shift_en & key_msb;
        end
    end

    assign Data_Valid    = dv_q;
    assign DataIN_mem    = mem_q;
    assign DataIN_cipher = cip_q;
    assign proto_err     = err_q;
    assign blocks_sent   = sent_q;

endmodule
